// File: rtl/fp_mul_arbiter.sv
`timescale 1ns/1ps
// fp_mul_arbiter
//   Round-robin scheduler sharing one external single-precision multiplier
//   between NUM_REQ requesters. Accepted operand pairs are issued through a
//   register stage to the multiplier. Each operation carries its requester
//   tag down a delay line matched to the multiplier latency. Results are
//   returned in issue order through a credit-protected result FIFO.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid[NUM_REQ]     requester i has an operand pair
//   req_a/req_b            packed operands, requester i in bits [32i+31:32i]
//   req_ready[NUM_REQ]     one-hot grant (accept = valid & ready)
//   mul_a/mul_b            registered operands to the multiplier
//   mul_z                  multiplier result, MUL_LATENCY cycles after mul_a/b
//   res_valid/res_ready    result handshake, FIFO head
//   res_tag/res_z          requester index and result of the FIFO head
module fp_mul_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int MUL_LATENCY = 2,
    parameter  int FIFO_DEPTH  = 4,
    localparam int TAG_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_z,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [TAG_W-1:0]      res_tag,
    output logic [31:0]           res_z
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [TAG_W-1:0]   ptr;
    logic [CW-1:0]      credit;

    logic               found;
    logic [TAG_W-1:0]   cand;
    logic [TAG_W-1:0]   grant_idx;
    logic               issue;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;

    // Stage 0 is aligned with mul_a/mul_b; stage MUL_LATENCY with mul_z.
    logic [MUL_LATENCY:0] pipe_v;
    logic [TAG_W-1:0]     pipe_tag [MUL_LATENCY+1];

    logic [31:0]        mem_z   [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = TAG_W'((32'(ptr) + i + 32'd1) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Credit covers both in-flight operations and FIFO occupancy, so an
    // issue can never produce a result without a free FIFO slot.
    assign issue = found & rst_n & (credit != '0);

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (TAG_W'(i) == grant_idx) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[PW-1] != rptr[PW-1]);
    assign res_valid = ~empty;
    assign pop       = res_valid & res_ready;
    // Full is unreachable with a valid emerging stage unless a pop frees
    // the slot in the same cycle; the guard just keeps storage safe.
    assign push      = pipe_v[MUL_LATENCY] & (~full | pop);
    assign res_z     = mem_z[rptr[AW-1:0]];
    assign res_tag   = mem_tag[rptr[AW-1:0]];

    // Arbitration state and issue register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= TAG_W'(NUM_REQ - 1);
            credit <= CW'(FIFO_DEPTH);
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            if (issue) begin
                ptr   <= grant_idx;
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            case ({issue, pop})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // Tag delay line tracking the multiplier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int unsigned s = 0; s <= MUL_LATENCY; s++) pipe_tag[s] <= '0;
        end else begin
            pipe_v[0]   <= issue;
            pipe_tag[0] <= grant_idx;
            for (int unsigned s = 1; s <= MUL_LATENCY; s++) begin
                pipe_v[s]   <= pipe_v[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    // Result FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                mem_z[e]   <= '0;
                mem_tag[e] <= '0;
            end
        end else begin
            if (push) begin
                mem_z[wptr[AW-1:0]]   <= mul_z;
                mem_tag[wptr[AW-1:0]] <= pipe_tag[MUL_LATENCY];
                wptr                  <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
`timescale 1ns/1ps
module tb_fp_mul_arbiter;

    localparam int NR = 4;
    localparam int ML = 2;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*32-1:0] req_a;
    logic [NR*32-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_z;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_tag;
    logic [31:0]     res_z;

    always #5 clk = ~clk;

    fp_mul_arbiter #(
        .NUM_REQ    (NR),
        .MUL_LATENCY(ML),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_z    (mul_z),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_tag  (res_tag),
        .res_z    (res_z)
    );

    // Float multiply for normal operands, truncating; exact for the values used.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
        return {s, e[7:0], m[45:23]};
    endfunction

    // Multiplier model: ideal multiply followed by a 2-stage delay line.
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= fmul(mul_a, mul_b);
        d2 <= d1;
    end
    assign mul_z = d2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: accepts are queued with the expected result, pops compared in order.
    typedef struct {
        logic [1:0]  tag;
        logic [31:0] z;
    } exp_t;
    exp_t q[$];
    int acc_cnt = 0;
    int pop_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (res_valid && res_ready) begin
                pop_cnt++;
                check("sb_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_tag", 32'(res_tag), 32'(e.tag));
                    check("sb_z", res_z, e.z);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cnt++;
                    q.push_back('{tag: 2'(i), z: fmul(req_a[32*i +: 32], req_b[32*i +: 32])});
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;
    vec_t vt[4];

    logic [31:0] pa[6];
    int idx, nacc, k, a0, p0;
    logic acc;
    logic [3:0] expg;

    initial begin
        vt[0] = '{2, 32'h40000000, 32'h40400000, 32'h40C00000}; // 2*3 = 6
        vt[1] = '{0, 32'h3FC00000, 32'hC0000000, 32'hC0400000}; // 1.5*-2 = -3
        vt[2] = '{3, 32'h3F000000, 32'h3F000000, 32'h3E800000}; // 0.5*0.5 = 0.25
        vt[3] = '{1, 32'h40E00000, 32'h41000000, 32'h42600000}; // 7*8 = 56
        pa = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};

        // Reset state, with all requesters valid to show gating
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        req_b     = req_a;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_z", res_z, 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single-request latency vectors
        res_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            req_a = {4{32'h7F7F0000}};
            req_b = {4{32'h00FF00FF}};
            set_req(vt[v].req, vt[v].a, vt[v].b);
            req_valid = '0;
            req_valid[vt[v].req] = 1'b1;
            @(negedge clk);
            check("vec_grant", 32'(req_ready), 32'd1 << vt[v].req);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check("vec_mul_a", mul_a, vt[v].a);
            check("vec_mul_b", mul_b, vt[v].b);
            @(negedge clk);
            @(negedge clk);
            check("vec_res_valid_c3", 32'(res_valid), 32'd0);
            @(negedge clk);
            check("vec_res_valid_c4", 32'(res_valid), 32'd1);
            check("vec_res_tag", 32'(res_tag), 32'(vt[v].req));
            check("vec_res_z", res_z, vt[v].z);
            @(posedge clk); #1;
        end

        // Continuous load: 0,1,2,3 then a credit bubble every fifth cycle
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 32'(32'h3F800000 + (i << 23)), 32'h40000000);
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            expg = (c % 5 == 4) ? 4'd0 : 4'(4'd1 << (c % 5));
            check("rr_grant", 32'(req_ready), 32'(expg));
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // Fairness between requesters 0 and 3
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b1001;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 5 == 4) expg = 4'd0;
            else begin
                expg = (k % 2 == 0) ? 4'b0001 : 4'b1000;
                k++;
            end
            check("fair_grant", 32'(req_ready), 32'(expg));
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // Backpressure: requester 1 offers 6 pairs with res_ready low
        do_reset();
        res_ready = 1'b0;
        idx = 0;
        nacc = 0;
        set_req(1, pa[0], 32'h40000000);
        req_valid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = req_ready[1];
            if (acc) nacc++;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) set_req(1, pa[idx], 32'h40000000);
            end
        end
        @(negedge clk);
        check("bp_accepts", 32'(nacc), 32'd4);
        check("bp_ready_zero", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("bp_head_valid", 32'(res_valid), 32'd1);
            check("bp_head_z", res_z, 32'h40000000);
            check("bp_head_tag", 32'(res_tag), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_first_pop_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_pop_ready", 32'(req_ready), 32'b0010);
        acc = req_ready[1];
        for (int c = 0; c < 20 && idx < 6; c++) begin
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) set_req(1, pa[idx], 32'h40000000);
            end
            @(negedge clk);
            acc = req_ready[1] && (idx < 6);
        end
        check("bp_all_accepted", 32'(idx), 32'd6);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_drained", 32'(res_valid), 32'd0);

        // Reset mid-flight
        do_reset();
        res_ready = 1'b0;
        set_req(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mf_accept", 32'(req_ready), 32'b0001);
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mf_pre_reset_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mf_res_valid_low", 32'(res_valid), 32'd0);
        end
        @(posedge clk); #1;
        set_req(2, 32'h40400000, 32'h40400000);
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mf_credit_accept", 32'(req_ready), 32'b0100);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mf_credit_exhausted", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Full FIFO then sustained push/pop traffic
        do_reset();
        res_ready = 1'b0;
        set_req(0, 32'h3FC00000, 32'h3FC00000);
        set_req(3, 32'h40A00000, 32'hBF800000);
        req_valid = 4'b1001;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("full_ready_zero", 32'(req_ready), 32'd0);
        check("full_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        a0 = acc_cnt;
        p0 = pop_cnt;
        res_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("full_res_empty", 32'(res_valid), 32'd0);
        check("full_pops_eq_accepts", 32'(pop_cnt - p0), 32'(acc_cnt - a0 + 4));
        check("sb_queue_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
